sum_seq_ctrl: RTL

Multi-cycle sequencer that adds two WIDTH-bit operands using a single 4-bit carry-lookahead slice (`sum_4b`), one nibble per cycle, LSB nibble first. The ripple carry between nibbles is held in a register. It sits between a requester issuing a start/done handshake and the shared `sum_4b` datapath. It trades latency for area against a flat WIDTH-bit adder.

---
 rtl/sum_seq_ctrl.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/sum_seq_ctrl.sv
// rtl/sum_seq_ctrl.sv - nibble-serial adder sequencer around a 4-bit carry-lookahead slice
//
// Adds two WIDTH-bit operands, one nibble per cycle with the LSB nibble first,
// through a single sum_4b slice. The carry between nibbles is held in a register.
// Requester handshake: start (accepted only in IDLE) -> busy -> one-cycle done.
//
// Optional feature macro: SUM_SEQ_CTRL_OVF_EN (adds the registered signed-overflow output ovf)
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   start  request, sampled only in IDLE
//   a, b   WIDTH-bit operands, sampled on the accepting edge
//   c_in   carry into bit 0, sampled on the accepting edge
//   busy   high whenever not IDLE
//   done   one-cycle pulse, sum/c_out valid
//   sum    registered WIDTH-bit result
//   c_out  registered carry out of bit WIDTH-1
//   ovf    (SUM_SEQ_CTRL_OVF_EN only) registered two's-complement overflow

module sum_4b (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g    = a & b;
  assign p    = a ^ b;
  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);
  assign s     = p ^ c[3:0];
  assign c_out = c[4];
endmodule

module sum_seq_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
`ifdef SUM_SEQ_CTRL_OVF_EN
  ,
  output logic             ovf
`endif
);
  localparam int N  = WIDTH / 4;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [3:0]       slice_a, slice_b, slice_s;
  logic             slice_c;
  logic             last;

  assign slice_a = a_reg[4*idx +: 4];
  assign slice_b = b_reg[4*idx +: 4];
  assign last    = (idx == IW'(N - 1));

  sum_4b u_slice (
    .a     (slice_a),
    .b     (slice_b),
    .c_in  (carry),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // done is decoded from the state register, so it never depends on start combinationally
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) next_state = RUN;
      RUN: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      a_reg <= '0;
      b_reg <= '0;
      carry <= 1'b0;
      sum   <= '0;
      c_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= b;
            carry <= c_in;
            idx   <= '0;
          end
        end
        RUN: begin
          sum[4*idx +: 4] <= slice_s;
          carry           <= slice_c;
          if (last) c_out <= slice_c;
          else      idx   <= idx + IW'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef SUM_SEQ_CTRL_OVF_EN
  // carry-in XOR carry-out of the MSB equals "operand signs agree but the result sign differs"
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (state == RUN && last) begin
      ovf <= (slice_a[3] == slice_b[3]) && (slice_s[3] != slice_a[3]);
    end
  end
`endif
endmodule
